// File: rtl/debounce_edge.sv
// debounce_edge: debounces a single-bit stream into a clean level.
// Emits one-cycle rise/fall strobes and a saturating rising-edge count.
//
// Optional feature (macro DEBOUNCE_SYNC_EN): when the macro is defined,
// a two-flop synchroniser sits in front of the FSM. Leave it undefined
// only when din is generated from clk.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   din      raw input bit
//   cnt_clr  synchronous clear of edge_cnt
//   level    debounced level
//   rise     one-cycle strobe on an accepted 0->1
//   fall     one-cycle strobe on an accepted 1->0
//   edge_cnt saturating count of accepted rises
module debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             cnt_clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] ONE = SW'(1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] C1 = CNT_W'(1);

  typedef enum logic [1:0] {
    LOW,
    LOW_CHK,
    HIGH,
    HIGH_CHK
  } state_t;

  state_t        st;
  logic [SW-1:0] stab;
  logic          s;
  logic          acc_rise;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], din};
    end
  end

  assign s = sync[1];
`else
  assign s = din;
`endif

  // Accepting rise decides the counter update together with cnt_clr.
  assign acc_rise = (st == LOW_CHK) && s && (stab == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= LOW;
      stab     <= '0;
      level    <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      edge_cnt <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (st)
        LOW: begin
          if (s) begin
            st   <= LOW_CHK;
            stab <= ONE;
          end
        end
        LOW_CHK: begin
          if (!s) begin
            st   <= LOW;
            stab <= '0;
          end else if (stab == LAST) begin
            st    <= HIGH;
            stab  <= '0;
            level <= 1'b1;
            rise  <= 1'b1;
          end else begin
            stab <= stab + ONE;
          end
        end
        HIGH: begin
          if (!s) begin
            st   <= HIGH_CHK;
            stab <= ONE;
          end
        end
        HIGH_CHK: begin
          if (s) begin
            st   <= HIGH;
            stab <= '0;
          end else if (stab == LAST) begin
            st    <= LOW;
            stab  <= '0;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            stab <= stab + ONE;
          end
        end
        default: begin
          st   <= LOW;
          stab <= '0;
        end
      endcase

      // A clear that lands on an accepted rise keeps that rise.
      if (acc_rise) begin
        if (cnt_clr) begin
          edge_cnt <= C1;
        end else if (edge_cnt != CMAX) begin
          edge_cnt <= edge_cnt + C1;
        end
      end else if (cnt_clr) begin
        edge_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge: random stimulus, windowed reference model,
// scoreboard queue drained by an independent monitor.
module tb_debounce_edge;

  localparam int N    = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int CYC  = 4000;
`ifdef DEBOUNCE_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          din;
  logic          cnt_clr;
  logic          level;
  logic          rise;
  logic          fall;
  logic [CW-1:0] edge_cnt;

  typedef struct {
    int cyc;
    bit level;
    bit rise;
    bit fall;
    int cnt;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  bit m_level;
  bit m_rise;
  bit m_fall;
  int m_cnt;
  bit hist[$];
  bit pipe[$];

  debounce_edge #(
    .STABLE_CYCLES(N),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .cnt_clr(cnt_clr),
    .level(level),
    .rise(rise),
    .fall(fall),
    .edge_cnt(edge_cnt)
  );

  always #5 clk = ~clk;

  function automatic void m_reset();
    m_level = 1'b0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_cnt   = 0;
    hist.delete();
    pipe.delete();
    pipe.push_back(1'b0);
    pipe.push_back(1'b0);
  endfunction

  // Level flips once the last N samples all disagree with it.
  function automatic void m_step(bit d, bit clr);
    bit s;
    bit flip;
    bit up;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (SYNC) begin
      s = pipe.pop_front();
      pipe.push_back(d);
    end else begin
      s = d;
    end
    hist.push_back(s);
    if (hist.size() > N) void'(hist.pop_front());
    flip = (hist.size() == N);
    foreach (hist[i]) if (hist[i] == m_level) flip = 1'b0;
    up = 1'b0;
    if (flip) begin
      m_level = !m_level;
      if (m_level) begin
        m_rise = 1'b1;
        up = 1'b1;
      end else begin
        m_fall = 1'b1;
      end
    end
    if (up && clr) m_cnt = 1;
    else if (clr) m_cnt = 0;
    else if (up && m_cnt < CMAX) m_cnt = m_cnt + 1;
  endfunction

  initial begin : driver
    bit p_rst;
    bit p_din;
    bit p_clr;
    int run_left;
    bit noisy;
    exp_t e;
    rst     = 1'b1;
    din     = 1'b0;
    cnt_clr = 1'b0;
    m_reset();
    p_rst    = 1'b1;
    p_din    = 1'b0;
    p_clr    = 1'b0;
    run_left = 0;
    noisy    = 1'b0;
    for (int c = 0; c < CYC; c++) begin
      @(posedge clk);
      #1;
      if (!p_rst) m_step(p_din, p_clr);
      if (c < 3) begin
        rst = 1'b1;
        din = 1'($urandom_range(0, 1));
        cnt_clr = 1'b0;
      end else begin
        rst = ($urandom_range(0, 99) < 2);
        cnt_clr = ($urandom_range(0, 99) < 8);
        if (run_left == 0) begin
          noisy = ($urandom_range(0, 9) == 0);
          run_left = $urandom_range(1, 8);
          din = !din;
        end
        if (noisy) din = 1'($urandom_range(0, 1));
        run_left--;
      end
      if (rst) m_reset();
      e.cyc   = c;
      e.level = m_level;
      e.rise  = m_rise;
      e.fall  = m_fall;
      e.cnt   = m_cnt;
      sbq.push_back(e);
      p_rst = rst;
      p_din = din;
      p_clr = cnt_clr;
    end
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: left=%0d want=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (level !== e.level || rise !== e.rise ||
            fall !== e.fall || int'(edge_cnt) != e.cnt ||
            $isunknown(edge_cnt)) begin
          errors++;
          $display(
            "FAIL outputs c=%0d: got l=%0b r=%0b f=%0b n=%0d want l=%0b r=%0b f=%0b n=%0d",
            e.cyc, level, rise, fall, edge_cnt,
            e.level, e.rise, e.fall, e.cnt);
        end
        checks++;
        if (rise === 1'b1 && fall === 1'b1) begin
          errors++;
          $display("FAIL strobes c=%0d: got rise=1 fall=1 want not both",
                   e.cyc);
        end
      end
    end
  end

endmodule
